row_compressor: RTL and testbench
=================================

# row_compressor

Serial run-length encoder for one binary feature-map row: the write-side counterpart of the row decompressor in the IO module. It accepts a rowSize-bit raw row and scans it one bit per clock, LSB first. It emits a rowSize-bit word of sectionSize-bit run lengths in the format the decompressor consumes. Rows that cannot be represented in that format are flagged with `error` instead of producing a wrong encoding.

## Interface
- `sectionSize`, 4, width of one run-length field; maximum encodable run is 2^sectionSize-1.
- `rowSize`, 16, raw row width and compressed word width; must be a multiple of sectionSize. numSections = rowSize/sectionSize is derived locally.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enable`  input  1  start request; sampled only in IDLE.
- `rawData`  input  rowSize  row to compress; sampled on the accepting edge only.
- `compressedData`  output  rowSize  encoded row, registered; valid when `done`=1 and held until the next accept.
- `done`  output  1  one-cycle pulse; result and `error` are valid.
- `busy`  output  1  high whenever the state is not IDLE.
- `error`  output  1  row is not encodable; registered alongside `compressedData`.

## Operation
- Encoding format:
  - Section k occupies bits [k*sectionSize +: sectionSize].
  - Section 0 holds the length of the run of 0s starting at bit 0; this may be 0 if bit 0 is 1.
  - Each following section holds the next run, with the bit value alternating 1, 0, 1, ….
  - The trailing run of 0s is never encoded. All unused sections are 0.
- States: IDLE → SCAN (exactly rowSize cycles) → EMIT (1 cycle) → IDLE.
- Accept: on a rising edge in IDLE with `enable`=1:
  - Latch `rawData`.
  - Clear bit index, run count, section index, working word and error flag.
  - Set current digit to 0.
- SCAN, one bit per cycle at index i:
  - If bit == current digit, increment the run count.
  - Otherwise, close the run: write count into the current section, advance the section index, toggle the current digit, and set count to 1.
  - Error condition (a): closing a run whose count exceeds 2^sectionSize-1 sets the sticky error flag.
  - Error condition (b): a section index reaching numSections before a write sets the sticky error flag.
  - The run counter is sectionSize+1 bits wide; it must not wrap before the overflow check.
  - Scanning continues after an error, so latency stays fixed.
- EMIT:
  - If the current digit is 1, close the final run with the same overflow and section checks.
  - If the current digit is 0, discard the final run. An all-zero row therefore encodes to 0.
  - Register `compressedData` = working word, or all zeros if error.
  - Register `error` and assert `done`.
- `enable` while `busy`=1 is ignored and is not queued.
- `rst`=1 on any edge, including mid-SCAN:
  - State goes to IDLE.
  - `compressedData`, `done`, `busy`, `error` and all internal counters go to 0.
  - `rst` wins over a simultaneous `enable`.
- Round trip: for every row with `error`=0, decompressing `compressedData` must return the original row.

## Timing
- Reset values: `compressedData`=0, `done`=0, `busy`=0, `error`=0.
- Let E0 be the accepting edge:
  - Bits 0..rowSize-1 are processed on edges E1..ErowSize.
  - EMIT occurs at edge ErowSize+1.
  - `done` is high for exactly the cycle following ErowSize+1 (default: after E17). The state is IDLE during that cycle.
- Latency from accept edge to `done` visible: rowSize+1 clocks. This is fixed and independent of data and error.
- `busy` rises the cycle after E0 and falls in the same cycle `done` rises.
- `enable` held high during the `done` cycle is accepted at the next edge. Back-to-back throughput is one row per rowSize+2 clocks.
- `compressedData` and `error` change only at EMIT or reset.

## Test plan
- Reset then idle: after `rst` high for 2 cycles, all outputs are 0. With no `enable`, `busy` and `done` stay 0 for 40 cycles.
- Encodable rows, each pulse checking exact latency of 17 clocks:
  - `rawData`=0x0000 → 0x0000, error 0.
  - 0x000F → 0x0040.
  - 0x00F0 → 0x0044.
  - 0x7FF0 → 0x00B4.
  - 0xFFFE → 0x00F1 (max run).
  - 0x8001 → 0x1E10 (all 4 sections used).
- Unencodable rows:
  - 0xFFFF (run of 16 ones) → `error`=1, `compressedData`=0x0000.
  - 0x5555 (too many runs) → `error`=1, `compressedData`=0x0000.
  - In both cases `done` still arrives at 17 clocks.
- Busy/back-to-back:
  - Accept 0x00F0, pulse `enable` with 0xFFFF at cycle 5 → ignored; result is 0x0044.
  - `enable` held through the `done` cycle → second row accepted; its `done` arrives 18 clocks after the first `done`.
- Reset mid-operation: `rst` at cycle 8 of SCAN → outputs 0 and `busy` 0 the next cycle, and no `done`. The next accept of 0x000F yields 0x0040. `rst` and `enable` asserted together → not accepted.
- Random round trip: 1000 random rows through the compressor, then the decompressor model. Every row with `error`=0 reproduces exactly. Every row with `error`=1 has a run >15 ones or more than 4 encoded runs.

Source files
------------

// File: rtl/row_compressor.sv
// row_compressor: serial run-length encoder for one binary feature-map row.
// Scans the latched row LSB first, one bit per clock, and packs alternating
// run lengths (0s first) into sectionSize-bit fields of a rowSize-bit word.
// Rows whose runs do not fit the format raise `error` and encode to zero.
//
// Handshake: `enable` is a request that is honoured only while the block is
// IDLE (busy=0); there is no back-pressure. The result is valid in the single
// cycle where `done`=1 and stays on `compressedData`/`error` until the next
// accepted row or reset. `enable` seen while busy=1 is dropped, not queued.
module row_compressor #(
    parameter int sectionSize = 4,
    parameter int rowSize     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [rowSize-1:0] rawData,
    output logic [rowSize-1:0] compressedData,
    output logic               done,
    output logic               busy,
    output logic               error,
    output logic [1:0]         stateDbg
);

    localparam int numSections = rowSize / sectionSize;
    localparam int cntW        = sectionSize + 1;
    localparam int secW        = $clog2(numSections + 1);
    localparam int idxW        = (rowSize > 1) ? $clog2(rowSize) : 1;

    // Longest run a section can hold.
    localparam logic [cntW-1:0] maxRun   = cntW'((1 << sectionSize) - 1);
    // Counter ceiling; holding here keeps an overlong run visibly overlong.
    localparam logic [cntW-1:0] cntSat   = '1;
    // First section index that does not exist.
    localparam logic [secW-1:0] secLimit = secW'(numSections);
    localparam logic [idxW-1:0] lastBit  = idxW'(rowSize - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } stateType;

    stateType state;
    stateType nextState;

    logic [rowSize-1:0] rowReg;
    logic [idxW-1:0]    bitIdx;
    logic [cntW-1:0]    runCount;
    logic [secW-1:0]    secIdx;
    logic [rowSize-1:0] workWord;
    logic               errFlag;
    logic               digit;

    logic               curBit;
    logic [rowSize-1:0] closedWord;
    logic               closedErr;
    logic [secW-1:0]    closedSecIdx;
    logic [rowSize-1:0] finalWord;
    logic               finalErr;

    assign busy     = (state != IDLE);
    assign stateDbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: accept in IDLE, scan exactly rowSize bits, one EMIT cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    nextState = SCAN;
                end
            end
            SCAN: begin
                if (bitIdx == lastBit) begin
                    nextState = EMIT;
                end
            end
            EMIT: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Bit under the scan pointer.
    always_comb begin
        curBit = rowReg[bitIdx];
    end

    // Effect of closing the current run: write its length into the current
    // section, or flag an error if the run is too long or no section is left.
    always_comb begin
        closedWord   = workWord;
        closedErr    = errFlag;
        closedSecIdx = secIdx;
        if (secIdx >= secLimit) begin
            closedErr = 1'b1;
        end else begin
            for (int k = 0; k < numSections; k++) begin
                if (secIdx == secW'(k)) begin
                    closedWord[k*sectionSize +: sectionSize] = runCount[sectionSize-1:0];
                end
            end
            closedSecIdx = secIdx + secW'(1);
        end
        if (runCount > maxRun) begin
            closedErr = 1'b1;
        end
    end

    // At EMIT a trailing run of 1s is closed; a trailing run of 0s is dropped.
    always_comb begin
        finalWord = workWord;
        finalErr  = errFlag;
        if (digit) begin
            finalWord = closedWord;
            finalErr  = closedErr;
        end
    end

    // Datapath: latch on accept, update run/section bookkeeping while
    // scanning, register the result and pulse done at EMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            rowReg         <= '0;
            bitIdx         <= '0;
            runCount       <= '0;
            secIdx         <= '0;
            workWord       <= '0;
            errFlag        <= 1'b0;
            digit          <= 1'b0;
            compressedData <= '0;
            error          <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        rowReg   <= rawData;
                        bitIdx   <= '0;
                        runCount <= '0;
                        secIdx   <= '0;
                        workWord <= '0;
                        errFlag  <= 1'b0;
                        digit    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (curBit == digit) begin
                        if (runCount != cntSat) begin
                            runCount <= runCount + cntW'(1);
                        end
                    end else begin
                        workWord <= closedWord;
                        errFlag  <= closedErr;
                        secIdx   <= closedSecIdx;
                        digit    <= ~digit;
                        runCount <= cntW'(1);
                    end
                    bitIdx <= bitIdx + idxW'(1);
                end
                EMIT: begin
                    compressedData <= finalErr ? '0 : finalWord;
                    error          <= finalErr;
                    done           <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_compressor.sv
// Bench for row_compressor: directed rows with literal results, busy and
// reset corner cases, and a random round trip through a decompressor model.
module tb_row_compressor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] rawData = '0;
    logic [W-1:0] compressedData;
    logic         done;
    logic         busy;
    logic         error;
    logic [1:0]   stateDbg;

    int testsRun = 0;
    int testsFailed = 0;

    // Clock.
    always #5 clk = ~clk;

    row_compressor #(.sectionSize(4), .rowSize(W)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .rawData(rawData),
        .compressedData(compressedData),
        .done(done),
        .busy(busy),
        .error(error),
        .stateDbg(stateDbg)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding: split the row into maximal runs (first run is 0s,
    // possibly empty), drop a trailing 0-run, then pack or reject.
    function automatic void encodeRow(input logic [W-1:0] row, output logic [W-1:0] word,
                                      output logic err, output int nRuns, output int maxOnes);
        int lens[$];
        int runLen;
        logic cur;
        cur = 1'b0;
        runLen = 0;
        for (int i = 0; i < W; i++) begin
            if (row[i] == cur) begin
                runLen++;
            end else begin
                lens.push_back(runLen);
                cur = row[i];
                runLen = 1;
            end
        end
        lens.push_back(runLen);
        if (cur == 1'b0) void'(lens.pop_back());
        nRuns = lens.size();
        maxOnes = 0;
        for (int k = 1; k < lens.size(); k += 2) begin
            if (lens[k] > maxOnes) maxOnes = lens[k];
        end
        err = (nRuns > W / 4) || (maxOnes > 15);
        for (int k = 0; k < lens.size(); k += 2) begin
            if (lens[k] > 15) err = 1'b1;
        end
        word = '0;
        if (!err) begin
            for (int k = 0; k < lens.size(); k++) word[k*4 +: 4] = 4'(lens[k]);
        end
    endfunction

    // Decompressor model: expand alternating 0/1 runs from section 0 upward.
    function automatic logic [W-1:0] decodeRow(input logic [W-1:0] word);
        logic [W-1:0] row;
        int pos;
        row = '0;
        pos = 0;
        for (int k = 0; k < W / 4; k++) begin
            for (int j = 0; j < int'(word[k*4 +: 4]); j++) begin
                if (pos < W) row[pos] = (k % 2 == 1);
                pos++;
            end
        end
        return row;
    endfunction

    // Scoreboard state, advanced on every rising edge.
    logic [W-1:0] expQ[$];
    logic         errQ[$];
    logic [W-1:0] rowQ[$];
    int           edgeN = 0;
    int           acceptEdge = 0;
    bit           active = 1'b0;
    int           doneEdge = -1;
    bit           modelValid = 1'b0;
    logic [W-1:0] heldData = '0;
    logic         heldErr = 1'b0;
    logic [W-1:0] lastRow = '0;
    logic [W-1:0] mWord;
    logic         mErr;
    int           mRuns;
    int           mOnes;

    always @(posedge clk) begin
        edgeN++;
        if (rst) begin
            modelValid = 1'b1;
            active = 1'b0;
            doneEdge = -1;
            heldData = '0;
            heldErr = 1'b0;
            expQ.delete();
            errQ.delete();
            rowQ.delete();
        end else if (active) begin
            if (edgeN == acceptEdge + W + 1) begin
                heldData = expQ.pop_front();
                heldErr = errQ.pop_front();
                lastRow = rowQ.pop_front();
                doneEdge = edgeN;
                active = 1'b0;
            end
        end else if (enable) begin
            encodeRow(rawData, mWord, mErr, mRuns, mOnes);
            expQ.push_back(mWord);
            errQ.push_back(mErr);
            rowQ.push_back(rawData);
            acceptEdge = edgeN;
            active = 1'b1;
        end
    end

    // Compare process: every cycle, all outputs against the scoreboard.
    logic [W-1:0] cWord;
    logic         cErr;
    int           cRuns;
    int           cOnes;

    always @(negedge clk) begin
        if (modelValid) begin
            checkVal("done", done, 32'(doneEdge == edgeN));
            checkVal("busy", busy, 32'(active));
            checkVal("compressedData", compressedData, heldData);
            checkVal("error", error, heldErr);
            if (doneEdge == edgeN && done === 1'b1) begin
                if (error === 1'b0) begin
                    checkVal("roundTrip", decodeRow(compressedData), lastRow);
                end else begin
                    encodeRow(lastRow, cWord, cErr, cRuns, cOnes);
                    checkVal("errorCause", 32'((cOnes > 15) || (cRuns > 4)), 32'd1);
                end
            end
        end
    end

    // Driver helpers.
    task automatic waitDone(input int bound, output bit got);
        got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic sendRow(input logic [W-1:0] row, input bit checkLit,
                           input logic [W-1:0] litWord, input logic litErr, input string name);
        int startEdge;
        bit got;
        @(negedge clk);
        enable = 1'b1;
        rawData = row;
        @(posedge clk);
        #1;
        startEdge = edgeN;
        enable = 1'b0;
        waitDone(30, got);
        checkVal({name, "_doneSeen"}, 32'(got), 32'd1);
        if (got) begin
            checkVal({name, "_latency"}, edgeN - startEdge, W + 1);
            if (checkLit) begin
                checkVal({name, "_data"}, compressedData, litWord);
                checkVal({name, "_error"}, error, litErr);
            end
        end
    endtask

    logic [W-1:0] litRow  [8] = '{16'h0000, 16'h000F, 16'h00F0, 16'h7FF0,
                                  16'hFFFE, 16'h8001, 16'hFFFF, 16'h5555};
    logic [W-1:0] litWord [8] = '{16'h0000, 16'h0040, 16'h0044, 16'h00B4,
                                  16'h00F1, 16'h1E10, 16'h0000, 16'h0000};
    logic         litErr  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [W-1:0] tWord;
        logic         tErr;
        int           tRuns;
        int           tOnes;
        int           bad;
        int           startEdge;
        bit           got;
        logic [W-1:0] raw;

        // Pin the model against hand-computed encodings.
        for (int i = 0; i < 8; i++) begin
            encodeRow(litRow[i], tWord, tErr, tRuns, tOnes);
            checkVal($sformatf("model_%04h_word", litRow[i]), tWord, litWord[i]);
            checkVal($sformatf("model_%04h_err", litRow[i]), tErr, litErr[i]);
        end

        // Reset for two cycles, then everything must be zero.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_data", compressedData, 0);
        checkVal("reset_done", done, 0);
        checkVal("reset_busy", busy, 0);
        checkVal("reset_error", error, 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no enable.
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checkVal("idle_quiet", bad, 0);

        // Directed rows with literal results.
        for (int i = 0; i < 8; i++) begin
            sendRow(litRow[i], 1'b1, litWord[i], litErr[i], $sformatf("row_%04h", litRow[i]));
        end

        // enable while busy is ignored.
        @(negedge clk);
        enable = 1'b1;
        rawData = 16'h00F0;
        @(posedge clk);
        #1;
        startEdge = edgeN;
        enable = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
        rawData = 16'hFFFF;
        @(negedge clk);
        enable = 1'b0;
        rawData = '0;
        waitDone(30, got);
        checkVal("busyIgnore_doneSeen", 32'(got), 1);
        checkVal("busyIgnore_latency", edgeN - startEdge, W + 1);
        checkVal("busyIgnore_data", compressedData, 16'h0044);
        checkVal("busyIgnore_error", error, 0);

        // enable held through the done cycle: next row accepted right away.
        @(negedge clk);
        enable = 1'b1;
        rawData = 16'h000F;
        @(posedge clk);
        #1;
        startEdge = edgeN;
        waitDone(30, got);
        checkVal("held_first_latency", edgeN - startEdge, W + 1);
        checkVal("held_first_data", compressedData, 16'h0040);
        rawData = 16'h8001;
        startEdge = edgeN;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (edgeN - startEdge == 1) enable = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        enable = 1'b0;
        checkVal("held_second_doneSeen", 32'(got), 1);
        checkVal("held_second_gap", edgeN - startEdge, W + 2);
        checkVal("held_second_data", compressedData, 16'h1E10);

        // Reset in the middle of a scan.
        @(negedge clk);
        enable = 1'b1;
        rawData = 16'h00F0;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkVal("midRst_busy", busy, 0);
        checkVal("midRst_done", done, 0);
        checkVal("midRst_data", compressedData, 0);
        checkVal("midRst_error", error, 0);
        @(negedge clk);
        rst = 1'b0;
        waitDone(25, got);
        checkVal("midRst_noDone", 32'(got), 0);
        sendRow(16'h000F, 1'b1, 16'h0040, 1'b0, "afterRst");

        // rst together with enable: no accept.
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        rawData = 16'h000F;
        @(posedge clk);
        #1;
        checkVal("rstEnable_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;
        checkVal("rstEnable_busyAfter", busy, 0);
        waitDone(25, got);
        checkVal("rstEnable_noDone", 32'(got), 0);

        // Random rows; the compare process checks values and round trip.
        for (int i = 0; i < 1000; i++) begin
            raw = 16'($urandom_range(0, 65535));
            if (i % 3 == 0) raw = 16'((32'h0000FFFF >> $urandom_range(0, 16)) << $urandom_range(0, 15));
            sendRow(raw, 1'b0, '0, 1'b0, "random");
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
